aq_vlsu_st_align_buffer: RTL
============================

Name: aq_vlsu_st_align_buffer

Overview:
- Store-side counterpart of the vector load align buffer.
- Accepts element-packed 64-bit vector store data beats, with valid bytes contiguous from byte 0.
- Rotates each beat to the memory byte lane given by the start address offset. Splits bytes that cross an 8-byte boundary into the following memory beat. Holds the leftover bytes in a residual register.
- Sits between the VPU store data read port and the LSU store data path. Presents lane-aligned data and byte strobes over a valid/ready handshake.

Parameters:
- DATAW, 64, data width in bits (fixed at 64).
- BYTEW, 8, data width in bytes (DATAW/8).

Ports:
- forever_cpuclk  input  1  clock.
- cpurst  input  1  reset, synchronous and active-high.
- rtu_yy_xx_flush  input  1  pipeline flush.
- src_vld  input  1  source beat valid.
- src_ready  output  1  source beat accepted when src_vld && src_ready.
- src_data  input  64  packed element data; byte i in bits [8i+7:8i].
- src_bytes_vld  input  8  thermometer code from bit 0; cnt = popcount, 0..8.
- src_first  input  1  first beat of an instruction; sampled only in IDLE.
- src_offset  input  3  start address[2:0]; valid with src_first.
- src_last  input  1  last beat of an instruction.
- mem_vld  output  1  memory beat valid.
- mem_ready  input  1  memory beat consumed when mem_vld && mem_ready.
- mem_data  output  64  lane-aligned store data.
- mem_bytes_vld  output  8  byte strobes.
- mem_last  output  1  final memory beat of the instruction.
- busy  output  1  state != IDLE || mem_vld.

Behaviour:
- State: st[1:0] in {IDLE, ACCUM, DRAIN}; ptr[2:0]; res_data[63:0]; res_bytes[7:0].
- Output register: one entry holding mem_vld, mem_data, mem_bytes_vld, mem_last.
- Reset (cpurst=1 at a clock edge), which also applies mid-operation:
  - st=IDLE, ptr=0, res_bytes=0.
  - mem_vld=0, mem_bytes_vld=0, mem_last=0, mem_data=0.
  - src_ready=0 during the reset cycle.
  - res_data is not reset.
- Flush (rtu_yy_xx_flush=1): same register effect as reset on the next edge. The in-flight output beat is dropped. A beat presented in the same cycle is not accepted.
- src_ready = !cpurst && !flush && st!=DRAIN && (!mem_vld || mem_ready).
- In IDLE, a beat is accepted only with src_first=1; when src_first=0, src_ready=0.
- Effective pointer: p = src_offset when accepting in IDLE, otherwise ptr. Define sum = p + cnt (4-bit).
- Lane mapping: input byte i (i < cnt) goes to lane (p+i) mod 8.
  - Lanes with p+i < 8 form cur_bytes/cur_data.
  - Lanes with p+i >= 8 form ovf_bytes/ovf_data.
  - Use a rotate-left by p, then mask.
- Merged beat: mrg_bytes = res_bytes | cur_bytes; mrg_data takes each byte from cur where cur_bytes is set, else from res.
- Actions on an accepted beat, evaluated in this order:
  1. sum < 8 && !src_last:
     - No emit.
     - res <= mrg; ptr <= sum[2:0]; st <= ACCUM.
  2. sum < 8 && src_last:
     - Emit mrg with mem_last=1.
     - res_bytes <= 0; st <= IDLE.
  3. sum == 8:
     - Emit mrg with mem_last=src_last.
     - res_bytes <= 0; ptr <= 0.
     - st <= src_last ? IDLE : ACCUM.
  4. sum > 8:
     - Emit mrg with mem_last=0.
     - res <= ovf; ptr <= sum[2:0].
     - st <= src_last ? DRAIN : ACCUM.
- DRAIN:
  - The output register loads res with mem_last=1 as soon as it is free (!mem_vld || mem_ready).
  - Then res_bytes <= 0; st <= IDLE.
- cnt == 0 beats:
  - Non-last: consumed with no state change.
  - Last: emits mrg, possibly with mem_bytes_vld=0, with mem_last=1.
- Latency: an emitted beat appears on mem_* one cycle after acceptance. Full throughput of 1 beat/cycle while mem_ready=1.
- Output register load: when it loads and mem_ready=1 in the same cycle, the old beat retires and the new one loads (no bubble).
- Stall: when mem_vld && !mem_ready, the mem_* outputs hold stable and src_ready=0.
- Bytes in mem_data where mem_bytes_vld=0 are don't-care. The implementation drives them to 0.

Optional Feature:
- Macro: VLSU_ST_ALIGN_SPLIT_CNT_EN.
- When defined:
  - Adds output split_cnt[15:0], counting accepted beats with sum > 8.
  - Saturates at 16'hFFFF.
  - Cleared by reset only; flush does not clear it.
- When undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- Aligned full beats: offset=0, 3 beats of bytes_vld=FF, last on beat 3, mem_ready=1.
  - Expect 3 mem beats of FF, mem_data equal to the inputs, mem_last only on beat 3, each one cycle after acceptance.
- Split: offset=5, one beat of 0x0807060504030201, bytes_vld=FF, last.
  - Beat 1: mem_bytes_vld=E0, data lanes 5..7 = 01,02,03.
  - Beat 2 (DRAIN): mem_bytes_vld=1F, lanes 0..4 = 04..08, mem_last=1.
  - src_ready=0 in DRAIN.
- Accumulate: offset=2, beat A bytes_vld=03, then beat B bytes_vld=0F, last.
  - A produces no emit.
  - Single beat mem_bytes_vld=FC, lanes 2,3 = A bytes 0,1, lanes 4..7 = B bytes 0..3, mem_last=1.
- Backpressure: scenario 2 with mem_ready=0 for 3 cycles after the first emit.
  - mem_* stable, src_ready=0, no beat lost or duplicated.
- Flush and reset mid-operation: flush during ACCUM with res_bytes=07, then assert cpurst during DRAIN.
  - Each time, next cycle: st=IDLE, mem_vld=0, res_bytes=0.
  - A new src_first beat is accepted afterwards with a clean offset.
- Macro enabled: 4 beats at offset=3 with bytes_vld=FF.
  - split_cnt=4; reset sets it to 0; flush leaves it unchanged.

Source files
------------

// File: rtl/aq_vlsu_st_align_buffer.sv
// Vector store align buffer: rotates element-packed store beats onto memory byte lanes,
// carrying bytes that cross an 8-byte boundary into the next beat. Optional: VLSU_ST_ALIGN_SPLIT_CNT_EN.
module aq_vlsu_st_align_buffer #(
    parameter int DATAW = 64,
    parameter int BYTEW = DATAW / 8
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst,
    input  logic             rtu_yy_xx_flush,
    input  logic             src_vld,
    output logic             src_ready,
    input  logic [DATAW-1:0] src_data,
    input  logic [BYTEW-1:0] src_bytes_vld,
    input  logic             src_first,
    input  logic [2:0]       src_offset,
    input  logic             src_last,
    output logic             mem_vld,
    input  logic             mem_ready,
    output logic [DATAW-1:0] mem_data,
    output logic [BYTEW-1:0] mem_bytes_vld,
    output logic             mem_last,
`ifdef VLSU_ST_ALIGN_SPLIT_CNT_EN
    output logic [15:0]      split_cnt,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           r_st;
    state_t           w_stNext;
    logic [2:0]       r_ptr;
    logic [2:0]       w_ptrNext;
    logic [DATAW-1:0] r_resData;
    logic [DATAW-1:0] w_resDataNext;
    logic [BYTEW-1:0] r_resBytes;
    logic [BYTEW-1:0] w_resBytesNext;

    logic             r_memVld;
    logic [DATAW-1:0] r_memData;
    logic [BYTEW-1:0] r_memBytes;
    logic             r_memLast;

    logic             w_load;
    logic [DATAW-1:0] w_loadData;
    logic [BYTEW-1:0] w_loadBytes;
    logic             w_loadLast;
    logic             w_splitHit;

    logic [3:0]         w_cnt;
    logic [2:0]         w_p;
    logic [3:0]         w_sum;
    logic [2*BYTEW-1:0] w_shBytes;
    logic [2*DATAW-1:0] w_shData;
    logic [BYTEW-1:0]   w_curBytes;
    logic [BYTEW-1:0]   w_ovfBytes;
    logic [DATAW-1:0]   w_curData;
    logic [DATAW-1:0]   w_ovfData;
    logic [DATAW-1:0]   w_resMasked;
    logic [BYTEW-1:0]   w_mrgBytes;
    logic [DATAW-1:0]   w_mrgData;
    logic               w_outFree;
    logic               w_accept;

    always_comb begin
        w_cnt = 4'd0;
        for (int i = 0; i < BYTEW; i++) begin
            w_cnt = w_cnt + {3'b000, src_bytes_vld[i]};
        end
    end

    // The start offset only matters on the first beat; later beats continue from ptr.
    assign w_p       = (r_st == ST_IDLE) ? src_offset : r_ptr;
    assign w_sum     = {1'b0, w_p} + w_cnt;
    assign w_shBytes = {{BYTEW{1'b0}}, src_bytes_vld} << w_p;
    assign w_shData  = {{DATAW{1'b0}}, src_data} << {w_p, 3'b000};
    assign w_curBytes = w_shBytes[BYTEW-1:0];
    assign w_ovfBytes = w_shBytes[2*BYTEW-1:BYTEW];

    // Invalid lanes are forced to zero so garbage above cnt never reaches memory.
    always_comb begin
        w_curData   = '0;
        w_ovfData   = '0;
        w_resMasked = '0;
        w_mrgData   = '0;
        for (int j = 0; j < BYTEW; j++) begin
            if (w_curBytes[j]) w_curData[8*j +: 8] = w_shData[8*j +: 8];
            if (w_ovfBytes[j]) w_ovfData[8*j +: 8] = w_shData[DATAW + 8*j +: 8];
            if (r_resBytes[j]) w_resMasked[8*j +: 8] = r_resData[8*j +: 8];
            w_mrgData[8*j +: 8] = w_curBytes[j] ? w_curData[8*j +: 8] : w_resMasked[8*j +: 8];
        end
    end

    assign w_mrgBytes = r_resBytes | w_curBytes;
    assign w_outFree  = !r_memVld || mem_ready;
    assign src_ready  = !cpurst && !rtu_yy_xx_flush && (r_st != ST_DRAIN) && w_outFree &&
                        ((r_st != ST_IDLE) || src_first);
    assign w_accept   = src_vld && src_ready;

    always_comb begin
        w_stNext       = r_st;
        w_ptrNext      = r_ptr;
        w_resDataNext  = r_resData;
        w_resBytesNext = r_resBytes;
        w_load         = 1'b0;
        w_loadData     = '0;
        w_loadBytes    = '0;
        w_loadLast     = 1'b0;
        w_splitHit     = 1'b0;
        if (r_st == ST_DRAIN) begin
            if (w_outFree) begin
                w_load         = 1'b1;
                w_loadData     = w_resMasked;
                w_loadBytes    = r_resBytes;
                w_loadLast     = 1'b1;
                w_resBytesNext = '0;
                w_ptrNext      = 3'd0;
                w_stNext       = ST_IDLE;
            end
        end else if (w_accept) begin
            if ((w_cnt == 4'd0) && !src_last) begin
                w_stNext = r_st;
            end else if ((w_sum < 4'd8) && !src_last) begin
                w_resDataNext  = w_mrgData;
                w_resBytesNext = w_mrgBytes;
                w_ptrNext      = w_sum[2:0];
                w_stNext       = ST_ACCUM;
            end else if (w_sum < 4'd8) begin
                w_load         = 1'b1;
                w_loadData     = w_mrgData;
                w_loadBytes    = w_mrgBytes;
                w_loadLast     = 1'b1;
                w_resBytesNext = '0;
                w_stNext       = ST_IDLE;
            end else if (w_sum == 4'd8) begin
                w_load         = 1'b1;
                w_loadData     = w_mrgData;
                w_loadBytes    = w_mrgBytes;
                w_loadLast     = src_last;
                w_resBytesNext = '0;
                w_ptrNext      = 3'd0;
                w_stNext       = src_last ? ST_IDLE : ST_ACCUM;
            end else begin
                // Crossing beat: overflow lanes become the residual for the next memory beat.
                w_load         = 1'b1;
                w_loadData     = w_mrgData;
                w_loadBytes    = w_mrgBytes;
                w_loadLast     = 1'b0;
                w_resDataNext  = w_ovfData;
                w_resBytesNext = w_ovfBytes;
                w_ptrNext      = w_sum[2:0];
                w_stNext       = src_last ? ST_DRAIN : ST_ACCUM;
                w_splitHit     = 1'b1;
            end
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst || rtu_yy_xx_flush) begin
            r_st       <= ST_IDLE;
            r_ptr      <= 3'd0;
            r_resBytes <= '0;
            r_memVld   <= 1'b0;
            r_memData  <= '0;
            r_memBytes <= '0;
            r_memLast  <= 1'b0;
        end else begin
            r_st       <= w_stNext;
            r_ptr      <= w_ptrNext;
            r_resBytes <= w_resBytesNext;
            if (w_load) begin
                r_memVld   <= 1'b1;
                r_memData  <= w_loadData;
                r_memBytes <= w_loadBytes;
                r_memLast  <= w_loadLast;
            end else if (mem_ready) begin
                r_memVld <= 1'b0;
            end
        end
    end

    // Residual data is qualified by r_resBytes, so it needs no reset.
    always_ff @(posedge forever_cpuclk) begin
        r_resData <= w_resDataNext;
    end

`ifdef VLSU_ST_ALIGN_SPLIT_CNT_EN
    logic [15:0] r_splitCnt;

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_splitCnt <= 16'd0;
        end else if (w_splitHit && (r_splitCnt != 16'hFFFF)) begin
            r_splitCnt <= r_splitCnt + 16'd1;
        end
    end

    assign split_cnt = r_splitCnt;
`endif

    assign mem_vld       = r_memVld;
    assign mem_data      = r_memData;
    assign mem_bytes_vld = r_memBytes;
    assign mem_last      = r_memLast;
    assign busy          = (r_st != ST_IDLE) || r_memVld;

endmodule
